// File: rtl/memctrl_host_pkg.sv
// Shared types and constants for the MEMCTRL host-side initiator.
package memctrl_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    RDWAIT,
    BRUN
  } state_t;

  localparam logic [2:0] BIST_MODE_OFF = 3'b000;
  localparam int         DEF_AW        = 16;
  localparam int         DEF_DW        = 8;

endpackage

// File: rtl/memctrl_host_if.sv
// Host initiator for MEMCTRL: turns valid/ready requests into command+gap strobes,
// returns read data on a response pulse, and sequences timed BIST runs.
//
// state  | meaning
// IDLE   | waiting for a request or a BIST start
// CMD    | command cycle, strobes asserted
// GAP    | first cycle after the command, strobes released
// RDWAIT | further read-latency cycles, OEB still low
// BRUN   | BIST_EN held for the fixed run window
module memctrl_host_if
  import memctrl_host_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int RD_LAT      = 1,
  parameter int BIST_CYCLES = 4200,
  parameter int BCW         = 13
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  output logic [DW-1:0] o_rsp_rdata,
  input  logic          i_bist_start,
  input  logic [2:0]    i_bist_mode_in,
  output logic          o_bist_done,
  output logic          o_bist_result,
  output logic [AW-1:0] o_addr,
  output logic          o_ce,
  output logic          o_csb,
  output logic [DW-1:0] o_idata,
  output logic          o_oeb,
  output logic          o_web,
  output logic          o_bist_en,
  output logic [2:0]    o_bist_mode,
  input  logic [DW-1:0] i_odata,
  input  logic          i_bist_pass
);

  localparam logic [BCW-1:0] LP_RD_LAST   = BCW'(RD_LAT);
  localparam logic [BCW-1:0] LP_BIST_LAST = BCW'(BIST_CYCLES - 1);

  state_t          r_state;
  logic [BCW-1:0]  r_cnt;
  logic            r_we;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_bist_done;
  logic            r_bist_result;
  logic [AW-1:0]   r_addr;
  logic            r_ce;
  logic            r_csb;
  logic [DW-1:0]   r_idata;
  logic            r_oeb;
  logic            r_web;
  logic            r_bist_en;
  logic [2:0]      r_bist_mode;
  logic            w_bist_go;

  // A qualifying BIST start wins the IDLE cycle, so the request is held off.
  assign w_bist_go   = i_bist_start && (i_bist_mode_in != BIST_MODE_OFF);
  assign o_req_ready = (r_state == IDLE) && !i_rst && !w_bist_go;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_bist_done   <= 1'b0;
      r_bist_result <= 1'b0;
      r_addr        <= '0;
      r_ce          <= 1'b0;
      r_csb         <= 1'b1;
      r_idata       <= '0;
      r_oeb         <= 1'b1;
      r_web         <= 1'b1;
      r_bist_en     <= 1'b0;
      r_bist_mode   <= BIST_MODE_OFF;
    end else begin
      r_rsp_valid <= 1'b0;
      r_bist_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_bist_go) begin
            r_state     <= BRUN;
            r_bist_en   <= 1'b1;
            r_bist_mode <= i_bist_mode_in;
            r_cnt       <= '0;
          end else if (i_req_valid) begin
            r_state <= CMD;
            r_we    <= i_req_we;
            r_addr  <= i_req_addr;
            r_ce    <= 1'b1;
            r_csb   <= 1'b0;
            r_web   <= !i_req_we;
            r_oeb   <= i_req_we;
            r_idata <= i_req_we ? i_req_wdata : '0;
          end
        end
        CMD: begin
          r_state <= GAP;
          r_ce    <= 1'b0;
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_idata <= '0;
          r_cnt   <= BCW'(1);
        end
        GAP, RDWAIT: begin
          if (r_we) begin
            r_state <= IDLE;
          end else if (r_cnt == LP_RD_LAST) begin
            r_rsp_rdata <= i_odata;
            r_rsp_valid <= 1'b1;
            r_oeb       <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= RDWAIT;
          end
        end
        BRUN: begin
          if (r_cnt == LP_BIST_LAST) begin
            r_bist_result <= i_bist_pass;
            r_bist_done   <= 1'b1;
            r_bist_en     <= 1'b0;
            r_bist_mode   <= BIST_MODE_OFF;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_bist_done   = r_bist_done;
  assign o_bist_result = r_bist_result;
  assign o_addr        = r_addr;
  assign o_ce          = r_ce;
  assign o_csb         = r_csb;
  assign o_idata       = r_idata;
  assign o_oeb         = r_oeb;
  assign o_web         = r_web;
  assign o_bist_en     = r_bist_en;
  assign o_bist_mode   = r_bist_mode;

endmodule

// File: tb/tb_memctrl_host_if.sv
// Bench for memctrl_host_if: two instances (RD_LAT 1 and 3) against a MEMCTRL
// model that only presents valid ODATA in the cycle the read must be sampled.
module tb_memctrl_host_if;

  localparam int BC = 50;
  localparam logic [42:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00,
                                     1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = '0, req_we = '0, bist_start = '0, bist_pass = '0;
  logic [15:0] req_addr [2];
  logic [7:0]  req_wdata [2];
  logic [2:0]  bist_mode_in [2];

  wire [1:0]  req_ready, rsp_valid, bist_done, bist_result, ce, csb, oeb, web, bist_en;
  wire [15:0] addr [2];
  wire [7:0]  rsp_rdata [2], idata [2], odata [2];
  wire [2:0]  bist_mode [2];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] shadow [2][256];

  memctrl_host_if #(.AW(16), .DW(8), .RD_LAT(1), .BIST_CYCLES(BC), .BCW(13)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0]), .i_bist_start(bist_start[0]),
    .i_bist_mode_in(bist_mode_in[0]), .o_bist_done(bist_done[0]), .o_bist_result(bist_result[0]),
    .o_addr(addr[0]), .o_ce(ce[0]), .o_csb(csb[0]), .o_idata(idata[0]), .o_oeb(oeb[0]),
    .o_web(web[0]), .o_bist_en(bist_en[0]), .o_bist_mode(bist_mode[0]), .i_odata(odata[0]),
    .i_bist_pass(bist_pass[0]));

  memctrl_host_if #(.AW(16), .DW(8), .RD_LAT(3), .BIST_CYCLES(BC), .BCW(13)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1]), .i_bist_start(bist_start[1]),
    .i_bist_mode_in(bist_mode_in[1]), .o_bist_done(bist_done[1]), .o_bist_result(bist_result[1]),
    .o_addr(addr[1]), .o_ce(ce[1]), .o_csb(csb[1]), .o_idata(idata[1]), .o_oeb(oeb[1]),
    .o_web(web[1]), .o_bist_en(bist_en[1]), .o_bist_mode(bist_mode[1]), .i_odata(odata[1]),
    .i_bist_pass(bist_pass[1]));

  // MEMCTRL model plus pulse/overlap monitors, one per instance.
  for (genvar g = 0; g < 2; g++) begin : g_mdl
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] mem [256];
    int lat_cnt  = 0;
    int rsp_cnt  = 0;
    int done_cnt = 0;
    int overlap  = 0;
    always @(posedge clk) begin
      if (ce[g] && !csb[g] && !web[g]) mem[addr[g][7:0]] <= idata[g];
      if (ce[g] && !csb[g] && !oeb[g]) lat_cnt <= 1;
      else if (lat_cnt != 0 && lat_cnt < LAT) lat_cnt <= lat_cnt + 1;
      else lat_cnt <= 0;
    end
    always @(negedge clk) begin
      if (rsp_valid[g]) rsp_cnt++;
      if (bist_done[g]) done_cnt++;
      if ((!web[g] && !oeb[g]) || (bist_en[g] && ce[g])) overlap++;
    end
    assign odata[g] = (lat_cnt == LAT) ? mem[addr[g][7:0]] : 8'hEE;
  end

  function automatic logic [42:0] obs_vec(input int s);
    return {ce[s], csb[s], oeb[s], web[s], addr[s], idata[s], bist_en[s], bist_mode[s],
            rsp_valid[s], rsp_rdata[s], bist_done[s], bist_result[s]};
  endfunction

  // Holds the request until accepted; returns #1 after the accepting edge (CMD cycle).
  task automatic issue(input int s, input logic we, input logic [15:0] a, input logic [7:0] d,
                       output bit ok);
    bit acc;
    ok = 1'b0;
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a; req_wdata[s] = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); acc = req_ready[s];
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    req_valid[s] = 1'b0; req_we[s] = 1'($urandom);
    req_addr[s] = 16'($urandom); req_wdata[s] = 8'($urandom);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout inst=%0d addr=%h got no accept, required accept", s, a);
    end else if (we) shadow[s][a[7:0]] = d;
    else exp_q.push_back(shadow[s][a[7:0]]);
  endtask

  task automatic wait_rsp(input int s, output int n);
    logic [7:0] e;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[s]) begin n = i; break; end
    end
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL rsp_timeout inst=%0d got no RSP_VALID, required a pulse", s);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL rsp_unexpected inst=%0d got data %h, required no response", s, rsp_rdata[s]);
    end else begin
      e = exp_q.pop_front();
      if (rsp_rdata[s] !== e) begin
        bad++;
        $display("FAIL rsp_data inst=%0d got %h required %h", s, rsp_rdata[s], e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL ready_in_reset got %b required 00", req_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (obs_vec(s) !== RST_VEC) begin
        bad++; $display("FAIL reset_vals inst=%0d got %h required %h", s, obs_vec(s), RST_VEC);
      end
    end
    total++;
    if (req_ready !== 2'b11) begin
      bad++; $display("FAIL ready_after_reset got %b required 11", req_ready);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    bit ok;
    issue(0, 1'b1, 16'h0005, 8'hA7, ok);
    total++;
    if ({ce[0], csb[0], web[0], oeb[0], idata[0], addr[0]} !== {4'b1001, 8'hA7, 16'h0005}) begin
      bad++; $display("FAIL write_cmd got %b %h %h required 1001 a7 0005",
                      {ce[0], csb[0], web[0], oeb[0]}, idata[0], addr[0]);
    end
    @(posedge clk); #1;
    total++;
    if ({ce[0], csb[0], web[0], oeb[0], idata[0], addr[0], req_ready[0]} !==
        {4'b0111, 8'h00, 16'h0005, 1'b0}) begin
      bad++; $display("FAIL write_gap got %b %h %h rdy=%b required 0111 00 0005 rdy=0",
                      {ce[0], csb[0], web[0], oeb[0]}, idata[0], addr[0], req_ready[0]);
    end
    @(posedge clk); #1;
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL write_ready_back got %b required 1", req_ready[0]);
    end
  endtask

  task automatic test_read();
    bit ok;
    logic [7:0] e;
    issue(0, 1'b0, 16'h0005, 8'h00, ok);
    total++;
    if ({ce[0], csb[0], web[0], oeb[0], idata[0]} !== {4'b1010, 8'h00}) begin
      bad++; $display("FAIL read_cmd got %b %h required 1010 00",
                      {ce[0], csb[0], web[0], oeb[0]}, idata[0]);
    end
    @(posedge clk); #1;
    total++;
    if ({ce[0], csb[0], web[0], oeb[0], rsp_valid[0]} !== 5'b01100) begin
      bad++; $display("FAIL read_gap got %b required 01100",
                      {ce[0], csb[0], web[0], oeb[0], rsp_valid[0]});
    end
    @(posedge clk); #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    total++;
    if ({rsp_valid[0], rsp_rdata[0], oeb[0], req_ready[0]} !== {1'b1, e, 1'b1, 1'b1}) begin
      bad++; $display("FAIL read_rsp got v=%b d=%h oeb=%b rdy=%b required v=1 d=%h oeb=1 rdy=1",
                      rsp_valid[0], rsp_rdata[0], oeb[0], req_ready[0], e);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid[0] !== 1'b0) begin
      bad++; $display("FAIL read_rsp_pulse got %b required 0", rsp_valid[0]);
    end
  endtask

  task automatic test_read_lat3();
    bit ok;
    int n;
    issue(1, 1'b1, 16'h0005, 8'hA7, ok);
    issue(1, 1'b0, 16'h0005, 8'h00, ok);
    wait_rsp(1, n);
    total++;
    if (n !== 4) begin
      bad++; $display("FAIL lat3_cycles got %0d required 4", n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n, base, ov;
    base = g_mdl[0].rsp_cnt;
    ov   = g_mdl[0].overlap;
    for (int i = 0; i < 10; i++) begin
      issue(0, 1'b1, 16'h0010 + 16'(i), 8'($urandom), ok);
      issue(0, 1'b0, 16'h0010 + 16'(i), 8'h00, ok);
      wait_rsp(0, n);
      total++;
      if (req_ready[0] !== 1'b1) begin
        bad++; $display("FAIL ready_on_rsp pair=%0d got %b required 1", i, req_ready[0]);
      end
    end
    repeat (2) @(posedge clk); #1;
    total++;
    if (g_mdl[0].rsp_cnt - base !== 10) begin
      bad++; $display("FAIL rsp_count got %0d required 10", g_mdl[0].rsp_cnt - base);
    end
    total++;
    if (g_mdl[0].overlap !== ov) begin
      bad++; $display("FAIL strobe_overlap got %0d required 0", g_mdl[0].overlap - ov);
    end
  endtask

  task automatic test_bist(input logic p);
    int en_cyc, fin;
    bist_pass[0] = p; bist_start[0] = 1'b1; bist_mode_in[0] = 3'b001;
    @(posedge clk); #1;
    bist_start[0] = 1'b0; bist_mode_in[0] = 3'($urandom);
    total++;
    if (bist_mode[0] !== 3'b001) begin
      bad++; $display("FAIL bist_mode_run got %b required 001", bist_mode[0]);
    end
    en_cyc = 0; fin = 0;
    for (int i = 0; i < 200; i++) begin
      if (bist_en[0]) en_cyc++;
      if (bist_done[0]) begin fin = 1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!fin || en_cyc !== BC) begin
      bad++; $display("FAIL bist_window got done=%0d en=%0d required done=1 en=%0d", fin, en_cyc, BC);
    end
    total++;
    if ({bist_result[0], bist_en[0], bist_mode[0]} !== {p, 1'b0, 3'b000}) begin
      bad++; $display("FAIL bist_result got %b required %b",
                      {bist_result[0], bist_en[0], bist_mode[0]}, {p, 4'b0000});
    end
    @(posedge clk); #1;
    total++;
    if ({bist_done[0], bist_result[0]} !== {1'b0, p}) begin
      bad++; $display("FAIL bist_done_pulse got %b required %b", {bist_done[0], bist_result[0]}, {1'b0, p});
    end
  endtask

  task automatic test_bist_priority();
    bit ok;
    int d0, n;
    d0 = g_mdl[0].done_cnt;
    bist_pass[0] = 1'b1; bist_start[0] = 1'b1; bist_mode_in[0] = 3'b010;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 16'h0020; req_wdata[0] = 8'h3C;
    @(negedge clk);
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL prio_ready got %b required 0", req_ready[0]);
    end
    @(posedge clk); #1;
    bist_start[0] = 1'b0;
    total++;
    if ({bist_en[0], ce[0]} !== 2'b10) begin
      bad++; $display("FAIL prio_bist_first got en,ce=%b required 10", {bist_en[0], ce[0]});
    end
    issue(0, 1'b1, 16'h0020, 8'h3C, ok);
    total++;
    if ({g_mdl[0].done_cnt - d0, bist_result[0], ce[0], idata[0]} !== {32'd1, 1'b1, 1'b1, 8'h3C}) begin
      bad++; $display("FAIL prio_req_after got done=%0d res=%b ce=%b d=%h required done=1 res=1 ce=1 d=3c",
                      g_mdl[0].done_cnt - d0, bist_result[0], ce[0], idata[0]);
    end
    issue(0, 1'b0, 16'h0020, 8'h00, ok);
    wait_rsp(0, n);
  endtask

  task automatic test_mode0();
    int en_cyc, d0;
    d0 = g_mdl[0].done_cnt;
    bist_start[0] = 1'b1; bist_mode_in[0] = 3'b000;
    @(negedge clk);
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL mode0_ready got %b required 1", req_ready[0]);
    end
    @(posedge clk); #1;
    bist_start[0] = 1'b0;
    en_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (bist_en[0]) en_cyc++;
      @(posedge clk); #1;
    end
    total++;
    if (en_cyc !== 0 || g_mdl[0].done_cnt !== d0) begin
      bad++; $display("FAIL mode0_ignored got en=%0d done=%0d required 0 0", en_cyc, g_mdl[0].done_cnt - d0);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int base;
    base = g_mdl[0].rsp_cnt;
    issue(0, 1'b0, 16'h0005, 8'h00, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs_vec(0) !== RST_VEC) begin
      bad++; $display("FAIL rst_mid_vals got %h required %h", obs_vec(0), RST_VEC);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    total++;
    if (g_mdl[0].rsp_cnt !== base) begin
      bad++; $display("FAIL rst_mid_no_rsp got %0d pulses required 0", g_mdl[0].rsp_cnt - base);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_addr[s] = '0; req_wdata[s] = '0; bist_mode_in[s] = '0;
    end
    test_reset();
    test_write();
    test_read();
    test_read_lat3();
    test_back_to_back();
    test_bist(1'b1);
    test_bist(1'b0);
    test_bist_priority();
    test_mode0();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
